vga_line_buffer_pp: RTL

//  Parametrised ping-pong video line buffer; successor to the fixed 1024x24 single-port line RAM.
//  Two banks of DEPTH words: the write side fills one bank while the read side drains the other.

---
 rtl/vga_line_buffer_pp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vga_line_buffer_pp.sv
// vga_line_buffer_pp: ping-pong video line buffer in the sys_clk domain.
// The write side fills one bank of DEPTH words while the read side drains the
// other. The banks swap on wr_eol. A stored line can be re-read any number of
// times; rd_sol rewinds the read index.
// Read latency is 2 cycles: a registered RAM output followed by an output register.
// Optional feature macro LB_PAD_EN: reads past the line end, but still inside
// the bank, return PAD_VALUE. This gives fixed-width output lines.
module vga_line_buffer_pp #(
  parameter int unsigned     DW        = 24,
  parameter int unsigned     AW        = 10,
  parameter logic [DW-1:0]   PAD_VALUE = '0
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_eol,
  input  logic          rd_sol,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [AW:0]   line_len,
  output logic          wr_ovf
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

  // Both banks share one simple dual-port array, addressed as {bank, index}.
  logic [DW-1:0] mem [0:2*DEPTH-1];

  // Bank, counter and length state.
  logic          wr_bank_reg, wr_bank_next;
  logic          rd_bank_reg, rd_bank_next;
  logic [AW:0]   wr_cnt_reg, wr_cnt_next;
  logic [AW:0]   rd_idx_reg, rd_idx_next;
  logic [AW:0]   line_len_reg, line_len_next;
  logic          wr_ovf_reg, wr_ovf_next;

  // Read pipeline: stage 1 runs alongside the RAM read, stage 2 is the output register.
  logic          s1_valid_reg, s1_last_reg, s1_pad_reg;
  logic [DW-1:0] ram_q_reg;
  logic [DW-1:0] rd_data_reg;
  logic          rd_valid_reg, rd_last_reg;

  // Combinational control.
  logic          wr_fire;
  logic [AW:0]   eff_idx, last_idx;
  logic          rd_hit, rd_pad, rd_accept;
  logic [AW:0]   wr_addr, rd_addr;

  // A write lands only while the bank has room. The counter stops at DEPTH,
  // so its top bit flags a full bank.
  always_comb begin
    wr_fire = wr_en & ~wr_cnt_reg[AW];
    wr_addr = {wr_bank_reg, wr_cnt_reg[AW-1:0]};
  end

  // Read accept decode. rd_sol forces the index to 0 in the same cycle.
  always_comb begin
    eff_idx  = rd_sol ? '0 : rd_idx_reg;
    last_idx = line_len_reg - IDX_ONE;
    rd_hit   = rd_en && (eff_idx < line_len_reg);
`ifdef LB_PAD_EN
    rd_pad   = rd_en && !rd_hit && !eff_idx[AW];
`else
    rd_pad   = 1'b0;
`endif
    rd_accept = rd_hit || rd_pad;
    rd_addr   = {rd_bank_reg, eff_idx[AW-1:0]};
  end

  // Next-state logic for banks, counters, line length and the sticky overflow flag.
  always_comb begin
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    wr_cnt_next   = wr_cnt_reg;
    line_len_next = line_len_reg;
    wr_ovf_next   = wr_ovf_reg;
    rd_idx_next   = rd_idx_reg;

    if (wr_fire)
      wr_cnt_next = wr_cnt_reg + IDX_ONE;
    if (wr_en && !wr_fire)
      wr_ovf_next = 1'b1;
    // A same-cycle write counts toward the latched length.
    if (wr_eol) begin
      line_len_next = wr_cnt_reg + {{AW{1'b0}}, wr_fire};
      wr_cnt_next   = '0;
      wr_bank_next  = ~wr_bank_reg;
      rd_bank_next  = wr_bank_reg;
    end

    // A bank swap leaves the read index alone; the consumer rewinds with rd_sol.
    if (rd_accept)
      rd_idx_next = eff_idx + IDX_ONE;
    else if (rd_sol)
      rd_idx_next = '0;
  end

  // Control state register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b1;
      wr_cnt_reg   <= '0;
      rd_idx_reg   <= '0;
      line_len_reg <= '0;
      wr_ovf_reg   <= 1'b0;
    end else begin
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      wr_cnt_reg   <= wr_cnt_next;
      rd_idx_reg   <= rd_idx_next;
      line_len_reg <= line_len_next;
      wr_ovf_reg   <= wr_ovf_next;
    end
  end

  // RAM write port. Contents survive reset; only new writes are held off during reset.
  always_ff @(posedge sys_clk) begin
    if (!reset && wr_fire)
      mem[wr_addr] <= wr_data;
  end

  // RAM read port with a registered output. It is not read for padded words.
  always_ff @(posedge sys_clk) begin
    if (rd_hit)
      ram_q_reg <= mem[rd_addr];
  end

  // Stage-1 tags travel with the RAM read. rd_last is decided at issue time.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_pad_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_accept;
      s1_last_reg  <= rd_hit && (eff_idx == last_idx);
      s1_pad_reg   <= rd_pad;
    end
  end

  // Output register: selects the RAM word or the pad word.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= s1_valid_reg;
      rd_last_reg  <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg)
        rd_data_reg <= s1_pad_reg ? PAD_VALUE : ram_q_reg;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_last  = rd_last_reg;
  assign line_len = line_len_reg;
  assign wr_ovf   = wr_ovf_reg;

endmodule
